// File: rtl/axi_lib_pkg.sv
// Shared AXI4-Lite definitions: response codes and the arbiter channel FSM states.
package axi_lib_pkg;

  localparam logic [1:0] AXI4_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI4_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI4_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI4_RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    ST_ARB_RD_IDLE,
    ST_ARB_RD_ADDR,
    ST_ARB_RD_DATA
  } st_axi_lite_arb_read_t;

  typedef enum logic [1:0] {
    ST_ARB_WR_IDLE,
    ST_ARB_WR_ADDR,
    ST_ARB_WR_DATA,
    ST_ARB_WR_RESP
  } st_axi_lite_arb_write_t;

endpackage

// File: rtl/axi4_lite_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first requesting index at or after ptr, wrapping.
module rr_arbiter #(
  parameter  int NUM_REQ = 2,
  localparam int PW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PW-1:0]      ptr,
  output logic [PW-1:0]      grant,
  output logic               any_req
);

  always_comb begin
    int   idx;
    logic found;
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      // Explicit wrap keeps non-power-of-two NUM_REQ correct.
      idx = int'(ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req[idx[PW-1:0]]) begin
        found = 1'b1;
        grant = idx[PW-1:0];
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/axi4_lite_arbiter.sv
// N:1 AXI4-Lite arbiter; read and write channels each own a round-robin pointer and
// FSM, and hold their grant from address handshake to response handshake.
module axi4_lite_arbiter
  import axi_lib_pkg::*;
#(
  parameter  int NUM_REQ        = 2,
  parameter  int ADDR_WIDTH     = 32,
  parameter  int AXI_DATA_WIDTH = 32,
  localparam int STRB_WIDTH     = AXI_DATA_WIDTH / 8,
  localparam int PW             = $clog2(NUM_REQ)
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic [NUM_REQ-1:0]                        req_arvalid,
  output logic [NUM_REQ-1:0]                        req_arready,
  input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]        req_araddr,
  output logic [NUM_REQ-1:0]                        req_rvalid,
  input  logic [NUM_REQ-1:0]                        req_rready,
  output logic [NUM_REQ-1:0][AXI_DATA_WIDTH-1:0]    req_rdata,
  output logic [NUM_REQ-1:0][1:0]                   req_rresp,
  input  logic [NUM_REQ-1:0]                        req_awvalid,
  output logic [NUM_REQ-1:0]                        req_awready,
  input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]        req_awaddr,
  input  logic [NUM_REQ-1:0]                        req_wvalid,
  output logic [NUM_REQ-1:0]                        req_wready,
  input  logic [NUM_REQ-1:0][AXI_DATA_WIDTH-1:0]    req_wdata,
  input  logic [NUM_REQ-1:0][STRB_WIDTH-1:0]        req_wstrb,
  output logic [NUM_REQ-1:0]                        req_bvalid,
  input  logic [NUM_REQ-1:0]                        req_bready,
  output logic [NUM_REQ-1:0][1:0]                   req_bresp,
  output logic                                      reg_arvalid,
  input  logic                                      reg_arready,
  output logic [ADDR_WIDTH-1:0]                     reg_araddr,
  input  logic                                      reg_rvalid,
  output logic                                      reg_rready,
  input  logic [AXI_DATA_WIDTH-1:0]                 reg_rdata,
  input  logic [1:0]                                reg_rresp,
  output logic                                      reg_awvalid,
  input  logic                                      reg_awready,
  output logic [ADDR_WIDTH-1:0]                     reg_awaddr,
  output logic                                      reg_wvalid,
  input  logic                                      reg_wready,
  output logic [AXI_DATA_WIDTH-1:0]                 reg_wdata,
  output logic [STRB_WIDTH-1:0]                     reg_wstrb,
  input  logic                                      reg_bvalid,
  output logic                                      reg_bready,
  input  logic [1:0]                                reg_bresp
);

  st_axi_lite_arb_read_t  rd_state_reg;
  st_axi_lite_arb_write_t wr_state_reg;
  logic [PW-1:0] rd_ptr_reg, rd_grant_reg, rd_arb_grant;
  logic [PW-1:0] wr_ptr_reg, wr_grant_reg, wr_arb_grant;
  logic          rd_any, wr_any;
  logic          rd_addr_ph, rd_data_ph, wr_addr_ph, wr_data_ph, wr_resp_ph;

  function automatic logic [PW-1:0] ptr_after(input logic [PW-1:0] g);
    return (g == PW'(NUM_REQ - 1)) ? '0 : g + 1'b1;
  endfunction

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rd_arb (
    .req     (req_arvalid),
    .ptr     (rd_ptr_reg),
    .grant   (rd_arb_grant),
    .any_req (rd_any)
  );

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_wr_arb (
    .req     (req_awvalid),
    .ptr     (wr_ptr_reg),
    .grant   (wr_arb_grant),
    .any_req (wr_any)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_state_reg <= ST_ARB_RD_IDLE;
      rd_ptr_reg   <= '0;
      rd_grant_reg <= '0;
    end else begin
      case (rd_state_reg)
        ST_ARB_RD_IDLE: if (rd_any) begin
          rd_grant_reg <= rd_arb_grant;
          rd_state_reg <= ST_ARB_RD_ADDR;
        end
        ST_ARB_RD_ADDR: if (reg_arvalid && reg_arready) rd_state_reg <= ST_ARB_RD_DATA;
        ST_ARB_RD_DATA: if (reg_rvalid && reg_rready) begin
          rd_ptr_reg   <= ptr_after(rd_grant_reg);
          rd_state_reg <= ST_ARB_RD_IDLE;
        end
        default: rd_state_reg <= ST_ARB_RD_IDLE;
      endcase
    end
  end

  // W is only forwarded from DATA, which is entered after the AW handshake.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_state_reg <= ST_ARB_WR_IDLE;
      wr_ptr_reg   <= '0;
      wr_grant_reg <= '0;
    end else begin
      case (wr_state_reg)
        ST_ARB_WR_IDLE: if (wr_any) begin
          wr_grant_reg <= wr_arb_grant;
          wr_state_reg <= ST_ARB_WR_ADDR;
        end
        ST_ARB_WR_ADDR: if (reg_awvalid && reg_awready) wr_state_reg <= ST_ARB_WR_DATA;
        ST_ARB_WR_DATA: if (reg_wvalid && reg_wready) wr_state_reg <= ST_ARB_WR_RESP;
        ST_ARB_WR_RESP: if (reg_bvalid && reg_bready) begin
          wr_ptr_reg   <= ptr_after(wr_grant_reg);
          wr_state_reg <= ST_ARB_WR_IDLE;
        end
        default: wr_state_reg <= ST_ARB_WR_IDLE;
      endcase
    end
  end

  assign rd_addr_ph = (rd_state_reg == ST_ARB_RD_ADDR);
  assign rd_data_ph = (rd_state_reg == ST_ARB_RD_DATA);
  assign wr_addr_ph = (wr_state_reg == ST_ARB_WR_ADDR);
  assign wr_data_ph = (wr_state_reg == ST_ARB_WR_DATA);
  assign wr_resp_ph = (wr_state_reg == ST_ARB_WR_RESP);

  assign reg_arvalid = rd_addr_ph & req_arvalid[rd_grant_reg];
  assign reg_araddr  = rd_addr_ph ? req_araddr[rd_grant_reg] : '0;
  assign reg_rready  = rd_data_ph & req_rready[rd_grant_reg];
  assign reg_awvalid = wr_addr_ph & req_awvalid[wr_grant_reg];
  assign reg_awaddr  = wr_addr_ph ? req_awaddr[wr_grant_reg] : '0;
  assign reg_wvalid  = wr_data_ph & req_wvalid[wr_grant_reg];
  assign reg_wdata   = wr_data_ph ? req_wdata[wr_grant_reg] : '0;
  assign reg_wstrb   = wr_data_ph ? req_wstrb[wr_grant_reg] : '0;
  assign reg_bready  = wr_resp_ph & req_bready[wr_grant_reg];

  genvar gi;
  for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
    logic rd_own, wr_own;
    assign rd_own = (rd_grant_reg == PW'(gi));
    assign wr_own = (wr_grant_reg == PW'(gi));

    assign req_arready[gi] = rd_addr_ph & rd_own & reg_arready;
    assign req_rvalid[gi]  = rd_data_ph & rd_own & reg_rvalid;
    assign req_rdata[gi]   = (rd_data_ph & rd_own) ? reg_rdata : '0;
    assign req_rresp[gi]   = (rd_data_ph & rd_own) ? reg_rresp : AXI4_RESP_SLVERR;

    assign req_awready[gi] = wr_addr_ph & wr_own & reg_awready;
    assign req_wready[gi]  = wr_data_ph & wr_own & reg_wready;
    assign req_bvalid[gi]  = wr_resp_ph & wr_own & reg_bvalid;
    assign req_bresp[gi]   = (wr_resp_ph & wr_own) ? reg_bresp : AXI4_RESP_SLVERR;
  end

endmodule

// File: tb/tb_axi4_lite_arbiter.sv
// Directed bench: three requesters sharing a behavioural register slave.
module tb_axi4_lite_arbiter;
  import axi_lib_pkg::*;

  localparam int N   = 3;
  localparam int TMO = 200;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]        arvalid = '0, arready, rvalid, rready = '0;
  logic [N-1:0]        awvalid = '0, awready, wvalid = '0, wready, bvalid, bready = '0;
  logic [N-1:0][31:0]  araddr = '0, awaddr = '0, wdata = '0, rdata;
  logic [N-1:0][3:0]   wstrb = '0;
  logic [N-1:0][1:0]   rresp, bresp;

  logic        m_arvalid, m_arready, m_rvalid, m_rready, m_awvalid, m_awready;
  logic        m_wvalid, m_wready, m_bvalid, m_bready;
  logic [31:0] m_araddr, m_awaddr, m_wdata, m_rdata;
  logic [3:0]  m_wstrb;
  logic [1:0]  m_rresp, m_bresp;

  axi4_lite_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(32), .AXI_DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_arvalid(arvalid), .req_arready(arready), .req_araddr(araddr),
    .req_rvalid(rvalid), .req_rready(rready), .req_rdata(rdata), .req_rresp(rresp),
    .req_awvalid(awvalid), .req_awready(awready), .req_awaddr(awaddr),
    .req_wvalid(wvalid), .req_wready(wready), .req_wdata(wdata), .req_wstrb(wstrb),
    .req_bvalid(bvalid), .req_bready(bready), .req_bresp(bresp),
    .reg_arvalid(m_arvalid), .reg_arready(m_arready), .reg_araddr(m_araddr),
    .reg_rvalid(m_rvalid), .reg_rready(m_rready), .reg_rdata(m_rdata), .reg_rresp(m_rresp),
    .reg_awvalid(m_awvalid), .reg_awready(m_awready), .reg_awaddr(m_awaddr),
    .reg_wvalid(m_wvalid), .reg_wready(m_wready), .reg_wdata(m_wdata), .reg_wstrb(m_wstrb),
    .reg_bvalid(m_bvalid), .reg_bready(m_bready), .reg_bresp(m_bresp)
  );

  // Register slave: 4 words, AW before W, one read and one write outstanding.
  // Address 0xC reads back EXOKAY so response pass-through is visible.
  logic [31:0] mem [4];
  logic        s_rvalid, s_aw_got, s_bvalid;
  logic [31:0] s_rdata, s_awaddr;
  logic [1:0]  s_rresp;

  assign m_arready = !s_rvalid;
  assign m_rvalid  = s_rvalid;
  assign m_rdata   = s_rdata;
  assign m_rresp   = s_rresp;
  assign m_awready = !s_aw_got && !s_bvalid;
  assign m_wready  = s_aw_got && !s_bvalid;
  assign m_bvalid  = s_bvalid;
  assign m_bresp   = AXI4_RESP_OKAY;

  always @(posedge clk) begin
    if (!rst_n) begin
      s_rvalid <= 1'b0; s_aw_got <= 1'b0; s_bvalid <= 1'b0;
      s_rdata <= '0; s_awaddr <= '0; s_rresp <= AXI4_RESP_OKAY;
      mem[0] <= 32'h1111_0000; mem[1] <= 32'hCAFE_0001;
      mem[2] <= 32'h2222_2222; mem[3] <= 32'h3333_3333;
    end else begin
      if (m_arvalid && m_arready) begin
        s_rvalid <= 1'b1;
        s_rdata  <= mem[m_araddr[3:2]];
        s_rresp  <= (m_araddr[3:2] == 2'd3) ? AXI4_RESP_EXOKAY : AXI4_RESP_OKAY;
      end else if (s_rvalid && m_rready) s_rvalid <= 1'b0;
      if (m_awvalid && m_awready) begin
        s_aw_got <= 1'b1;
        s_awaddr <= m_awaddr;
      end
      if (m_wvalid && m_wready) begin
        mem[s_awaddr[3:2]] <= m_wdata;
        s_aw_got <= 1'b0;
        s_bvalid <= 1'b1;
      end else if (s_bvalid && m_bready) s_bvalid <= 1'b0;
    end
  end

  // Monitor samples settled signals mid-cycle; counts are never cleared, tests use deltas.
  int ar_q[$], aw_q[$];
  int m_ar_cnt = 0, ov_cnt = 0, rv1_cnt = 0, b0_cnt = 0, b1_cnt = 0;
  always begin
    @(negedge clk); #2;
    for (int i = 0; i < N; i++) begin
      if (arvalid[i] && arready[i]) ar_q.push_back(i);
      if (awvalid[i] && awready[i]) aw_q.push_back(i);
    end
    if (m_arvalid && m_arready) m_ar_cnt++;
    if (m_arvalid && m_awvalid) ov_cnt++;
    if (rvalid[1]) rv1_cnt++;
    if (bvalid[0]) b0_cnt++;
    if (bvalid[1]) b1_cnt++;
  end

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    arvalid = '0; rready = '0; awvalid = '0; wvalid = '0; bready = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic do_read(input int id, input logic [31:0] addr,
                         output logic [31:0] data, output logic [1:0] resp);
    int cnt;
    @(negedge clk);
    arvalid[id] = 1'b1; araddr[id] = addr; rready[id] = 1'b1;
    cnt = 0; #1;
    while (arready[id] !== 1'b1 && cnt < TMO) begin @(negedge clk); #1; cnt++; end
    chk("ar_wait_in_budget", cnt < TMO, 1'b1);
    @(posedge clk);
    @(negedge clk);
    arvalid[id] = 1'b0;
    cnt = 0; #1;
    while (rvalid[id] !== 1'b1 && cnt < TMO) begin @(negedge clk); #1; cnt++; end
    chk("r_wait_in_budget", cnt < TMO, 1'b1);
    data = rdata[id];
    resp = rresp[id];
    @(posedge clk);
    @(negedge clk);
    rready[id] = 1'b0;
    $display("read  req%0d addr=%h data=%h resp=%0d", id, addr, data, resp);
  endtask

  task automatic do_write(input int id, input logic [31:0] addr, input logic [31:0] data,
                          output logic [1:0] resp);
    int cnt;
    @(negedge clk);
    awvalid[id] = 1'b1; awaddr[id] = addr;
    wvalid[id] = 1'b1; wdata[id] = data; wstrb[id] = 4'hF; bready[id] = 1'b1;
    cnt = 0; #1;
    while (awready[id] !== 1'b1 && cnt < TMO) begin @(negedge clk); #1; cnt++; end
    chk("aw_wait_in_budget", cnt < TMO, 1'b1);
    @(posedge clk);
    @(negedge clk);
    awvalid[id] = 1'b0;
    cnt = 0; #1;
    while (wready[id] !== 1'b1 && cnt < TMO) begin @(negedge clk); #1; cnt++; end
    chk("w_wait_in_budget", cnt < TMO, 1'b1);
    @(posedge clk);
    @(negedge clk);
    wvalid[id] = 1'b0;
    cnt = 0; #1;
    while (bvalid[id] !== 1'b1 && cnt < TMO) begin @(negedge clk); #1; cnt++; end
    chk("b_wait_in_budget", cnt < TMO, 1'b1);
    resp = bresp[id];
    @(posedge clk);
    @(negedge clk);
    bready[id] = 1'b0;
    $display("write req%0d addr=%h data=%h resp=%0d", id, addr, data, resp);
  endtask

  logic [31:0] d0, d1, d2;
  logic [1:0]  r0, r1, r2;
  int base, base2;

  initial begin
    // Reset state
    do_reset();
    #1;
    chk("rst_reg_arvalid", m_arvalid, 1'b0);
    chk("rst_reg_awvalid", m_awvalid, 1'b0);
    chk("rst_reg_wvalid", m_wvalid, 1'b0);
    chk("rst_reg_rready", m_rready, 1'b0);
    chk("rst_reg_bready", m_bready, 1'b0);
    chk("rst_req_readies", {arready, awready, wready}, 9'b0);
    chk("rst_req_valids", {rvalid, bvalid}, 6'b0);
    chk("rst_req_rdata", rdata, 96'b0);
    chk("rst_req_rresp", rresp, 6'b10_10_10);
    chk("rst_req_bresp", bresp, 6'b10_10_10);
    chk("rst_rd_state", dut.rd_state_reg, ST_ARB_RD_IDLE);
    chk("rst_wr_state", dut.wr_state_reg, ST_ARB_WR_IDLE);
    chk("rst_ptrs", {dut.rd_ptr_reg, dut.wr_ptr_reg}, 4'b0);
    chk("rst_grants", {dut.rd_grant_reg, dut.wr_grant_reg}, 4'b0);

    // Read, no contention
    base = m_ar_cnt; base2 = rv1_cnt;
    do_read(0, 32'h4, d0, r0);
    chk("rd_solo_data", d0, 32'hCAFE_0001);
    chk("rd_solo_resp", r0, AXI4_RESP_OKAY);
    chk("rd_solo_req1_rvalid_cycles", rv1_cnt - base2, 0);
    chk("rd_solo_downstream_ar_count", m_ar_cnt - base, 1);

    // Read contention straight after reset, then a second simultaneous pair
    do_reset();
    base = ar_q.size();
    fork
      do_read(0, 32'h4, d0, r0);
      do_read(1, 32'h0, d1, r1);
    join
    chk("contend1_count", ar_q.size() - base, 2);
    chk("contend1_first", ar_q[base], 0);
    chk("contend1_second", ar_q[base+1], 1);
    chk("contend1_req1_data", d1, 32'h1111_0000);
    chk("contend1_req0_data", d0, 32'hCAFE_0001);
    base = ar_q.size();
    fork
      do_read(0, 32'h8, d0, r0);
      do_read(1, 32'hC, d1, r1);
    join
    chk("contend2_first", ar_q[base], 0);
    chk("contend2_second", ar_q[base+1], 1);
    chk("contend2_req0_data", d0, 32'h2222_2222);
    chk("contend2_req1_resp_passthru", r1, AXI4_RESP_EXOKAY);
    chk("contend2_req1_data", d1, 32'h3333_3333);

    // Concurrent read (req1) and write (req0)
    do_reset();
    base = ov_cnt; base2 = b1_cnt;
    fork
      do_read(1, 32'h0, d1, r1);
      do_write(0, 32'h8, 32'h1234, r0);
    join
    chk("conc_rd_data", d1, 32'h1111_0000);
    chk("conc_bresp", r0, AXI4_RESP_OKAY);
    chk("conc_ar_aw_overlap", ov_cnt > base, 1'b1);
    chk("conc_req1_bvalid_cycles", b1_cnt - base2, 0);
    do_read(1, 32'h8, d1, r1);
    chk("conc_readback", d1, 32'h1234);

    // Backpressure: req0 holds rready low for 5 cycles
    do_reset();
    @(negedge clk);
    arvalid[0] = 1'b1; araddr[0] = 32'h4; rready[0] = 1'b0;
    arvalid[1] = 1'b1; araddr[1] = 32'h0; rready[1] = 1'b0;
    @(negedge clk); #1;
    chk("bp_grant0", dut.rd_grant_reg, 0);
    chk("bp_arready0", arready[0], 1'b1);
    chk("bp_arready1_addr", arready[1], 1'b0);
    @(negedge clk);
    arvalid[0] = 1'b0;
    #1;
    chk("bp_rvalid0", rvalid[0], 1'b1);
    chk("bp_rdata0", rdata[0], 32'hCAFE_0001);
    for (int k = 0; k < 5; k++) begin
      chk("bp_hold_grant", dut.rd_grant_reg, 0);
      chk("bp_hold_arready1", arready[1], 1'b0);
      @(negedge clk); #1;
    end
    rready[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rready[0] = 1'b0;
    #1;
    chk("bp_idle_after_r", dut.rd_state_reg, ST_ARB_RD_IDLE);
    chk("bp_idle_arready1", arready[1], 1'b0);
    chk("bp_ptr_after_r", dut.rd_ptr_reg, 1);
    @(negedge clk); #1;
    chk("bp_grant1", dut.rd_grant_reg, 1);
    chk("bp_arready1_granted", arready[1], 1'b1);
    @(posedge clk);
    @(negedge clk);
    arvalid[1] = 1'b0; rready[1] = 1'b1;
    #1;
    chk("bp_rvalid1", rvalid[1], 1'b1);
    chk("bp_rdata1", rdata[1], 32'h1111_0000);
    @(posedge clk);
    @(negedge clk);
    rready[1] = 1'b0;
    $display("read  req1 after backpressure data=%h", 32'h1111_0000);

    // Reset while the write FSM is in DATA
    do_reset();
    base = b0_cnt;
    @(negedge clk);
    awvalid[0] = 1'b1; awaddr[0] = 32'hC; wvalid[0] = 1'b1;
    wdata[0] = 32'hDEAD_BEEF; wstrb[0] = 4'hF; bready[0] = 1'b1;
    @(negedge clk); #1;
    chk("mid_wr_addr_state", dut.wr_state_reg, ST_ARB_WR_ADDR);
    @(negedge clk); #1;
    chk("mid_wr_data_state", dut.wr_state_reg, ST_ARB_WR_DATA);
    chk("mid_wr_wvalid_fwd", m_wvalid, 1'b1);
    rst_n = 1'b0;
    @(negedge clk); #1;
    chk("mid_rst_awvalid", m_awvalid, 1'b0);
    chk("mid_rst_wvalid", m_wvalid, 1'b0);
    chk("mid_rst_wr_state", dut.wr_state_reg, ST_ARB_WR_IDLE);
    chk("mid_rst_rd_state", dut.rd_state_reg, ST_ARB_RD_IDLE);
    chk("mid_rst_ptrs", {dut.rd_ptr_reg, dut.wr_ptr_reg}, 4'b0);
    chk("mid_rst_bvalid0", bvalid[0], 1'b0);
    awvalid[0] = 1'b0; wvalid[0] = 1'b0; bready[0] = 1'b0;
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    chk("mid_rst_no_bvalid_after", b0_cnt - base, 0);
    chk("mid_rst_wr_state_after", dut.wr_state_reg, ST_ARB_WR_IDLE);
    $display("write req0 dropped by reset");

    // Fairness: three requesters with back-to-back writes
    do_reset();
    base = aw_q.size();
    fork
      begin do_write(0, 32'h0, 32'hA0, r0); do_write(0, 32'h0, 32'hA1, r0); end
      begin do_write(1, 32'h4, 32'hB0, r1); do_write(1, 32'h4, 32'hB1, r1); end
      begin do_write(2, 32'h8, 32'hC0, r2); do_write(2, 32'h8, 32'hC1, r2); end
    join
    chk("fair_count", aw_q.size() - base, 6);
    for (int k = 0; k < 6; k++) chk("fair_order", aw_q[base+k], k % 3);
    do_read(2, 32'h8, d2, r2);
    chk("fair_last_write_req2", d2, 32'hC1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
